mux4_1bit_core: RTL and testbench

- 1-bit, 4-input selector. One of A/B/C/D is routed to OUT combinationally, chosen by the 2-bit sel.
- Also provides a registered copy of the selected bit (OUT_Q) for callers that need a flopped result.
- Leaf cell in the lab ALU datapath. It is replicated per bit and per-function by the ALU result-select logic.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mux4_1bit_core.sv | 89 ++++++++
 tb/tb_mux4_1bit_core.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the lab ALU datapath. The select codes below are used
// both by the per-bit result multiplexers (mux4_1bit_core) and by the ALU
// result-select logic that drives their sel inputs. Keeping one definition
// means an encoding change can only be made in one place.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Width of a result-select code.
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    // Select encodings: which data input a 4:1 result mux routes to its output.
    localparam sel_t SEL_A = 2'd0;
    localparam sel_t SEL_B = 2'd1;
    localparam sel_t SEL_C = 2'd2;
    localparam sel_t SEL_D = 2'd3;

endpackage : alu_pkg

// File: rtl/mux4_1bit_core.sv
// -----------------------------------------------------------------------------
// mux4_1bit_core
// 1-bit, 4-input selector used as a leaf cell of the lab ALU datapath. It is
// replicated per bit and per function; wider selectors are built by
// instantiating one of these per bit.
//
// OUT is the combinational selected bit (zero latency, independent of clk,
// rst and en, valid during reset). OUT_Q is a flopped copy of OUT that loads
// on the rising clock edge when en is high.
//
// Parameters
//   RESET_VAL      value held in OUT_Q while rst is asserted
//   REG_EN_DEFAULT value an integrator ties en to when the load enable is not
//                  used (1 = OUT_Q follows OUT every cycle)
//
// Ports
//   clk    in  1  system clock, OUT_Q updates on the rising edge
//   rst    in  1  asynchronous active-high reset of OUT_Q
//   A..D   in  1  data inputs, selected by sel = 0..3
//   sel    in  2  select code (alu_pkg::SEL_*)
//   en     in  1  load enable for OUT_Q, no effect on OUT
//   OUT    out 1  combinational selected bit
//   OUT_Q  out 1  registered selected bit
// -----------------------------------------------------------------------------
module mux4_1bit_core
    import alu_pkg::*;
#(
    parameter logic RESET_VAL      = 1'b0,
    parameter logic REG_EN_DEFAULT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic [1:0] sel,
    input  logic       en,
    output logic       OUT,
    output logic       OUT_Q
);

    logic out_s;
    logic load_s;
    logic out_q_r;

    // Select one of the four data inputs. An X/Z select falls through to the
    // default and yields X, so an undriven select is visible in simulation
    // rather than being masked to one of the inputs.
    always_comb begin
        out_s = 1'b0;
        case (sel)
            SEL_A:   out_s = A;
            SEL_B:   out_s = B;
            SEL_C:   out_s = C;
            SEL_D:   out_s = D;
            default: out_s = 1'bx;
        endcase
    end

    // Register load decision. Both tie-off settings load exactly when en is
    // high; REG_EN_DEFAULT only tells the integrator what to tie en to when
    // the enable is not wanted, so the live input always has the final say.
    always_comb begin
        load_s = 1'b0;
        if (REG_EN_DEFAULT) begin
            load_s = en;
        end else begin
            load_s = en;
        end
    end

    // Flopped copy of the selected bit. Reset is asynchronous, so OUT_Q
    // drops to RESET_VAL the moment rst rises, even mid-cycle, and a reset
    // released on a clock edge still holds RESET_VAL for that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_r <= RESET_VAL;
        end else if (load_s) begin
            out_q_r <= out_s;
        end else begin
            out_q_r <= out_q_r;
        end
    end

    assign OUT   = out_s;
    assign OUT_Q = out_q_r;

endmodule : mux4_1bit_core

// File: tb/tb_mux4_1bit_core.sv
// -----------------------------------------------------------------------------
// tb_mux4_1bit_core
// Directed, self-checking bench for mux4_1bit_core. Expected values are pushed
// onto a queue when stimulus is applied and popped when the DUT output is
// sampled, either #1 after the input change (OUT) or #1 after the rising
// clock edge (OUT_Q).
// -----------------------------------------------------------------------------
module tb_mux4_1bit_core;

    logic       clk;
    logic       rst;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic [1:0] sel;
    logic       en;
    logic       OUT;
    logic       OUT_Q;

    int checks;
    int errors;

    // Scoreboard of expected values, in the order they will be sampled.
    logic exp_q[$];

    mux4_1bit_core #(
        .RESET_VAL      (1'b0),
        .REG_EN_DEFAULT (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .sel   (sel),
        .en    (en),
        .OUT   (OUT),
        .OUT_Q (OUT_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference selector: index a 4-bit vector with the select code.
    function automatic logic ref_mux(input logic a, input logic b,
                                     input logic c, input logic d,
                                     input logic [1:0] s);
        logic [3:0] v;
        v = {d, c, b, a};
        return v[s];
    endfunction

    task automatic expect_val(input logic v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic obs);
        logic exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%b", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b, input logic c,
                         input logic d, input logic [1:0] s);
        A   = a;
        B   = b;
        C   = c;
        D   = d;
        sel = s;
    endtask

    initial begin
        logic [5:0] v;
        checks = 0;
        errors = 0;

        rst = 1'b1;
        en  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Reset state of the register.
        tick();
        expect_val(1'b0);
        check("reset_q", OUT_Q);

        // OUT is valid while in reset.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
        #1;
        expect_val(1'b1);
        check("out_in_reset", OUT);
        tick();
        expect_val(1'b0);
        check("reset_q_held", OUT_Q);

        // Release mid-cycle with sel=0, A=1: no load before the next edge.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        rst = 1'b0;
        #1;
        expect_val(1'b0);
        check("q_before_edge", OUT_Q);
        tick();
        expect_val(1'b1);
        check("q_first_load", OUT_Q);

        // en=0: OUT_Q holds 1 across three edges while OUT drops to 0.
        en = 1'b0;
        A  = 1'b0;
        #1;
        expect_val(1'b0);
        check("out_en0", OUT);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_val(1'b1);
            check("q_hold_en0", OUT_Q);
        end

        // Asynchronous reset asserted between edges.
        en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        expect_val(1'b0);
        check("q_async_rst", OUT_Q);
        A = 1'b1;
        #1;
        expect_val(1'b1);
        check("out_track_rst", OUT);
        tick();
        expect_val(1'b0);
        check("q_rst_held", OUT_Q);
        rst = 1'b0;

        // Select each input.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        #1; expect_val(1'b1); check("sel0", OUT);
        sel = 2'd1;
        #1; expect_val(1'b0); check("sel1", OUT);
        sel = 2'd2;
        #1; expect_val(1'b1); check("sel2", OUT);

        // Data change on the selected input.
        C = 1'b0;
        #1; expect_val(1'b0); check("sel2_c0", OUT);
        sel = 2'd3;
        #1; expect_val(1'b0); check("sel3_d0", OUT);
        D = 1'b1;
        #1; expect_val(1'b1); check("sel3_d1", OUT);

        // Unselected inputs do not disturb OUT.
        sel = 2'd1;
        B   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 6'(i);
            A = v[0];
            C = v[1];
            D = v[2];
            #1;
            expect_val(1'b1);
            check("isolation", OUT);
        end

        // Exhaustive: OUT immediately, OUT_Q one clock later.
        en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            drive(v[0], v[1], v[2], v[3], v[5:4]);
            #1;
            expect_val(ref_mux(v[0], v[1], v[2], v[3], v[5:4]));
            check("exh_out", OUT);
            expect_val(ref_mux(v[0], v[1], v[2], v[3], v[5:4]));
            tick();
            check("exh_q", OUT_Q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux4_1bit_core
